// File: rtl/serdesphy_pkg.sv
// -----------------------------------------------------------------------------
// serdesphy_pkg
// Shared types and defaults for the SerDes PHY link bring-up controller:
//   - link_state_t : FSM state encoding (codes are visible on the state port)
//   - link_ctrl_t  : bundle of enable/status outputs driven by the FSM
//   - *_DEFAULT    : default lock timeouts, training window and thresholds
//   - decode_ctrl  : Moore output decode for a given state
// -----------------------------------------------------------------------------
package serdesphy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLL_WAIT = 3'd1,
    ST_CDR_WAIT = 3'd2,
    ST_TRAIN    = 3'd3,
    ST_LINK_UP  = 3'd4,
    ST_FAULT    = 3'd5
  } link_state_t;

  typedef struct packed {
    logic pll_en;
    logic tx_en;
    logic rx_en;
    logic prbs_gen_en;
    logic prbs_chk_en;
    logic link_up;
    logic fault;
  } link_ctrl_t;

  localparam int PLL_TO_DEFAULT     = 4096;
  localparam int CDR_TO_DEFAULT     = 8192;
  localparam int PRBS_WIN_DEFAULT   = 1024;
  localparam int ERR_THRESH_DEFAULT = 4;
  localparam int MAX_RETRY_DEFAULT  = 3;

  // PLL lock must be seen high for this many consecutive cycles before the
  // controller trusts it.
  localparam int LOCK_STABLE_CYCLES = 16;

  function automatic link_ctrl_t decode_ctrl(input link_state_t s);
    link_ctrl_t c;
    c = '0;
    case (s)
      ST_PLL_WAIT: begin
        c.pll_en = 1'b1;
      end
      ST_CDR_WAIT: begin
        c.pll_en      = 1'b1;
        c.tx_en       = 1'b1;
        c.rx_en       = 1'b1;
        c.prbs_gen_en = 1'b1;
      end
      ST_TRAIN: begin
        c.pll_en      = 1'b1;
        c.tx_en       = 1'b1;
        c.rx_en       = 1'b1;
        c.prbs_gen_en = 1'b1;
        c.prbs_chk_en = 1'b1;
      end
      ST_LINK_UP: begin
        c.pll_en  = 1'b1;
        c.tx_en   = 1'b1;
        c.rx_en   = 1'b1;
        c.link_up = 1'b1;
      end
      ST_FAULT: begin
        c.fault = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serdesphy_sync2.sv
// -----------------------------------------------------------------------------
// serdesphy_sync2
// Two-flop synchronizer for a single asynchronous level signal.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops
//   d     - asynchronous input
//   q     - synchronized output (2-cycle latency)
// -----------------------------------------------------------------------------
module serdesphy_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: flops are written with non-blocking assignments so that q samples
  // the previous value of meta; blocking here would collapse the two stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serdesphy_link_ctrl.sv
// -----------------------------------------------------------------------------
// serdesphy_link_ctrl
// Link bring-up controller for a SerDes PHY. Sequences PLL lock, CDR lock and
// a PRBS training window, retries failed attempts and parks in FAULT once the
// retry budget is exhausted.
// Parameters:
//   PLL_TO     - PLL lock timeout (cycles in PLL_WAIT)
//   CDR_TO     - CDR lock timeout (cycles in CDR_WAIT)
//   PRBS_WIN   - training window length (cycles in TRAIN)
//   ERR_THRESH - error count at or above which training fails
//   MAX_RETRY  - consecutive failures that lead to FAULT
// Ports:
//   clk_ref_24m - sole clock
//   rst_n       - asynchronous active-low reset
//   enable      - link enable (synchronous); low forces IDLE
//   pll_lock    - asynchronous PLL lock level
//   cdr_lock    - asynchronous CDR lock level
//   prbs_err    - synchronous PRBS checker error pulse
//   pll_en, tx_en, rx_en, prbs_gen_en, prbs_chk_en - PHY enables (registered)
//   link_up, fault - status (registered)
//   state       - current FSM state code
//   retry_cnt   - consecutive failed attempts
// -----------------------------------------------------------------------------
module serdesphy_link_ctrl
  import serdesphy_pkg::*;
#(
  parameter int PLL_TO     = PLL_TO_DEFAULT,
  parameter int CDR_TO     = CDR_TO_DEFAULT,
  parameter int PRBS_WIN   = PRBS_WIN_DEFAULT,
  parameter int ERR_THRESH = ERR_THRESH_DEFAULT,
  parameter int MAX_RETRY  = MAX_RETRY_DEFAULT
) (
  input  logic       clk_ref_24m,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       pll_lock,
  input  logic       cdr_lock,
  input  logic       prbs_err,
  output logic       pll_en,
  output logic       tx_en,
  output logic       rx_en,
  output logic       prbs_gen_en,
  output logic       prbs_chk_en,
  output logic       link_up,
  output logic       fault,
  output logic [2:0] state,
  output logic [1:0] retry_cnt
);

  // One shared state timer serves every timed state, so it is sized for the
  // longest of them. It never needs to exceed (limit - 1).
  localparam int TIMER_MAX = (PLL_TO > CDR_TO)
                             ? ((PLL_TO > PRBS_WIN) ? PLL_TO : PRBS_WIN)
                             : ((CDR_TO > PRBS_WIN) ? CDR_TO : PRBS_WIN);
  localparam int TW = (TIMER_MAX > 2) ? $clog2(TIMER_MAX) : 1;

  // ---------------------------------------------------------------------------
  // Lock synchronizers
  // ---------------------------------------------------------------------------
  logic pll_s;
  logic cdr_s;

  serdesphy_sync2 u_sync_pll (
    .clk   (clk_ref_24m),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (pll_s)
  );

  serdesphy_sync2 u_sync_cdr (
    .clk   (clk_ref_24m),
    .rst_n (rst_n),
    .d     (cdr_lock),
    .q     (cdr_s)
  );

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  link_state_t   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    err_q,   err_d;
  logic [3:0]    lock_q,  lock_d;
  logic [1:0]    retry_q, retry_d;
  link_ctrl_t    ctrl_q;

  logic          fail;
  logic          enter;

  // Error count including this cycle's pulse, saturating at 255. The window
  // decision uses this so a pulse on the last window cycle still counts.
  logic [7:0] err_sum;
  logic [1:0] retry_inc;
  logic       lock_stable;
  logic       pll_timeout;
  logic       cdr_timeout;
  logic       win_end;

  assign err_sum     = (err_q == 8'hFF) ? err_q : err_q + {7'd0, prbs_err};
  assign retry_inc   = retry_q + 2'd1;
  assign lock_stable = pll_s && (lock_q == 4'(LOCK_STABLE_CYCLES - 1));
  assign pll_timeout = (timer_q == TW'(PLL_TO - 1));
  assign cdr_timeout = (timer_q == TW'(CDR_TO - 1));
  assign win_end     = (timer_q == TW'(PRBS_WIN - 1));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default at the top of the block; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_PLL_WAIT;
      end
      // Lock checks come before timeouts so a lock on the timeout cycle wins.
      ST_PLL_WAIT: begin
        if (lock_stable)      state_d = ST_CDR_WAIT;
        else if (pll_timeout) fail    = 1'b1;
      end
      ST_CDR_WAIT: begin
        if (cdr_s)            state_d = ST_TRAIN;
        else if (cdr_timeout) fail    = 1'b1;
      end
      ST_TRAIN: begin
        if (!cdr_s) begin
          fail = 1'b1;
        end else if (win_end) begin
          if (32'(err_sum) < ERR_THRESH) state_d = ST_LINK_UP;
          else                            fail    = 1'b1;
        end
      end
      ST_LINK_UP: begin
        // PLL loss invalidates the whole attempt; CDR loss alone just needs
        // the receiver to reacquire.
        if (!pll_s)      fail    = 1'b1;
        else if (!cdr_s) state_d = ST_CDR_WAIT;
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: state_d = ST_IDLE;
    endcase

    if (fail) begin
      retry_d = retry_inc;
      state_d = (retry_inc == 2'(MAX_RETRY)) ? ST_FAULT : ST_PLL_WAIT;
    end

    if (state_d == ST_LINK_UP && state_q != ST_LINK_UP) retry_d = 2'd0;

    // Disabling the link overrides every other decision.
    if (!enable) begin
      state_d = ST_IDLE;
      retry_d = 2'd0;
    end
  end

  // A failure that re-enters PLL_WAIT from PLL_WAIT is still a fresh entry,
  // hence the explicit fail term.
  assign enter = fail || (state_d != state_q);

  always_comb begin
    timer_d = timer_q;
    err_d   = err_q;
    lock_d  = 4'd0;

    if (enter) begin
      timer_d = '0;
      err_d   = 8'd0;
    end else begin
      if (state_q == ST_PLL_WAIT || state_q == ST_CDR_WAIT ||
          state_q == ST_TRAIN) begin
        timer_d = timer_q + TW'(1);
      end
      if (state_q == ST_TRAIN) err_d = err_sum;
      if (state_q == ST_PLL_WAIT && pll_s) lock_d = lock_q + 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers; outputs are decoded from the next state and registered so they
  // change on the same edge as state.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_ref_24m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      err_q   <= 8'd0;
      lock_q  <= 4'd0;
      retry_q <= 2'd0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      lock_q  <= lock_d;
      retry_q <= retry_d;
      ctrl_q  <= decode_ctrl(state_d);
    end
  end

  assign pll_en      = ctrl_q.pll_en;
  assign tx_en       = ctrl_q.tx_en;
  assign rx_en       = ctrl_q.rx_en;
  assign prbs_gen_en = ctrl_q.prbs_gen_en;
  assign prbs_chk_en = ctrl_q.prbs_chk_en;
  assign link_up     = ctrl_q.link_up;
  assign fault       = ctrl_q.fault;
  assign state       = state_q;
  assign retry_cnt   = retry_q;

endmodule

// File: doc/serdesphy_link_ctrl.md
SERDESPHY_LINK_CTRL -- requirements
Module: serdesphy_link_ctrl

Interface
REQ-001 SHALL have parameter PLL_TO, default 4096, PLL lock timeout in clk_ref_24m cycles.
REQ-002 SHALL have parameter CDR_TO, default 8192, CDR lock timeout in cycles.
REQ-003 SHALL have parameter PRBS_WIN, default 1024, training error-count window in cycles.
REQ-004 SHALL have parameter ERR_THRESH, default 4, minimum error count that fails training.
REQ-005 SHALL have parameter MAX_RETRY, default 3, number of consecutive failed attempts that leads to FAULT.
REQ-006 SHALL have port clk_ref_24m, input, 1, sole clock.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1, CSR link enable, synchronous to clk_ref_24m.
REQ-009 SHALL have port pll_lock, input, 1, asynchronous PLL lock indicator.
REQ-010 SHALL have port cdr_lock, input, 1, asynchronous CDR lock indicator.
REQ-011 SHALL have port prbs_err, input, 1, synchronous per-cycle PRBS checker error pulse.
REQ-012 SHALL have port pll_en, output, 1, PLL enable.
REQ-013 SHALL have ports tx_en and rx_en, output, 1 each, driver and receiver enables.
REQ-014 SHALL have ports prbs_gen_en and prbs_chk_en, output, 1 each, PRBS generator and checker enables.
REQ-015 SHALL have ports link_up and fault, output, 1 each, status.
REQ-016 SHALL have port state, output, 3, current FSM state code.
REQ-017 SHALL have port retry_cnt, output, 2, count of consecutive failed attempts.

Function
REQ-018 SHALL pass pll_lock and cdr_lock through 2-flop synchronizers; all FSM decisions SHALL use the synchronized versions.
REQ-019 SHALL implement states with these codes: IDLE=0, PLL_WAIT=1, CDR_WAIT=2, TRAIN=3, LINK_UP=4, FAULT=5.
REQ-020 SHALL force the next state to IDLE when enable=0, from any state; this rule SHALL take priority over all others; retry_cnt SHALL clear in the same cycle.
REQ-021 SHALL move from IDLE to PLL_WAIT when enable=1.
REQ-022 In PLL_WAIT, SHALL move to CDR_WAIT once synchronized pll_lock has been high for 16 consecutive cycles; any low cycle SHALL restart the 16-cycle count.
REQ-023 In CDR_WAIT, SHALL move to TRAIN on the first cycle synchronized cdr_lock=1.
REQ-024 In TRAIN, SHALL count prbs_err pulses for PRBS_WIN cycles with an 8-bit saturating counter.
REQ-025 At the end of the TRAIN window, SHALL go to LINK_UP if the error count is below ERR_THRESH, otherwise it SHALL record a failure.
REQ-026 The state timer SHALL clear on every state entry; reaching PLL_TO-1 in PLL_WAIT or CDR_TO-1 in CDR_WAIT SHALL record a failure.
REQ-027 If a lock condition and a timeout occur in the same cycle, the lock SHALL win.
REQ-028 Loss of synchronized cdr_lock in TRAIN SHALL record a failure.
REQ-029 In LINK_UP, loss of pll_lock SHALL record a failure; loss of cdr_lock alone SHALL move to CDR_WAIT without recording a failure.
REQ-030 A failure SHALL increment retry_cnt; if the new value equals MAX_RETRY, next state SHALL be FAULT, otherwise PLL_WAIT.
REQ-031 Entry into LINK_UP SHALL clear retry_cnt.
REQ-032 FAULT SHALL be left only by enable=0.
REQ-033 Outputs SHALL be Moore-decoded from registered state:
- pll_en=1 in PLL_WAIT, CDR_WAIT, TRAIN and LINK_UP.
- tx_en and rx_en=1 in CDR_WAIT, TRAIN and LINK_UP.
- prbs_gen_en=1 in CDR_WAIT and TRAIN.
- prbs_chk_en=1 in TRAIN only.
- link_up=1 in LINK_UP only; fault=1 in FAULT only.
REQ-034 A state change SHALL appear on the outputs one cycle after the deciding input is sampled; input-to-decision latency is 2 cycles (synchronizer) for pll_lock and cdr_lock.

Reset
REQ-035 rst_n low SHALL asynchronously set state=IDLE, clear the timer, error count, retry_cnt and synchronizers, and drive all enable and status outputs to 0.
REQ-036 Release of rst_n SHALL be synchronous.
REQ-037 Reset asserted mid-training SHALL abort the attempt with no retained count.

Structure
REQ-038 Package serdesphy_pkg SHALL hold the state enum and the default timeout, window and threshold constants.
REQ-039 The synchronizer SHALL be one sub-module, serdesphy_sync2, instantiated twice.

Verification (bench parameters: PLL_TO=64, CDR_TO=64, PRBS_WIN=32, ERR_THRESH=2, MAX_RETRY=2)
REQ-040 Happy path: enable=1, pll_lock high at cycle 5, cdr_lock high at cycle 40, no errors -> link_up=1 within 32+4 cycles of TRAIN entry; retry_cnt=0.
REQ-041 PLL timeout: pll_lock held 0 -> retry_cnt=1 after 64 cycles in PLL_WAIT, then FAULT after the second timeout; fault=1 and all enables=0.
REQ-042 Training errors: 2 prbs_err pulses inside the window -> failure and return to PLL_WAIT; 1 pulse -> LINK_UP.
REQ-043 Link drops: in LINK_UP, drop cdr_lock -> CDR_WAIT with retry_cnt unchanged; drop pll_lock -> PLL_WAIT with retry_cnt=1.
REQ-044 Priority: enable=0 in the same cycle as a timeout -> IDLE with retry_cnt=0; cdr_lock rising on the CDR timeout cycle -> TRAIN.
REQ-045 Reset: assert rst_n in TRAIN -> all outputs 0 immediately; on release, state=IDLE.
